mux_serializer: RTL and testbench
=================================

// Module: mux_serializer
//
// PURPOSE
//   Parallel-to-serial front end for the WIDTH:1 mux. Accepts one WIDTH-bit
//   word over a valid/ready handshake and holds it on the mux data inputs.
//   Steps the mux select through every bit position and returns the mux
//   output as a serial bit stream over a second valid/ready handshake.
//   Sits directly upstream of mux (drives a, s; consumes y).
//
// PARAMETERS
//   WIDTH      8   word width; power of two, >= 2; SEL_W = $clog2(WIDTH)
//   MSB_FIRST  0   0: bit order 0..WIDTH-1; 1: bit order WIDTH-1..0
//
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   in_data    in   WIDTH  word to serialize
//   in_valid   in   1      in_data valid
//   in_ready   out  1      block can accept a word this cycle
//   mux_a      out  WIDTH  held word, to mux data input a
//   mux_s      out  SEL_W  current bit index, to mux select s
//   mux_y      in   1      mux output, = mux_a[mux_s] combinationally
//   ser_bit    out  1      serial bit (= mux_y)
//   ser_valid  out  1      ser_bit valid
//   ser_ready  in   1      downstream accepts ser_bit this cycle
//   ser_last   out  1      current beat is the final bit of the word
//
// BEHAVIOUR
//   - Reset (async, rst_n low): state IDLE, mux_a = 0, mux_s = 0,
//     ser_valid = 0, ser_last = 0, in_ready = 1. Any word in flight is dropped.
//   - States: IDLE, SHIFT. mux_a, mux_s and the state are registered.
//   - FIRST = MSB_FIRST ? WIDTH-1 : 0;  LASTI = MSB_FIRST ? 0 : WIDTH-1.
//   - IDLE: in_ready = 1, ser_valid = 0. On in_valid: mux_a <= in_data,
//     mux_s <= FIRST, go to SHIFT.
//   - SHIFT: ser_valid = 1, ser_bit = mux_y, ser_last = (mux_s == LASTI).
//     On ser_ready and not last: mux_s steps by +1 (or -1 if MSB_FIRST).
//     On ser_ready and last: go to IDLE, unless a new word is accepted in the
//     same cycle (see below).
//   - Stall: with ser_ready low, mux_a, mux_s, ser_bit, ser_last and
//     ser_valid hold unchanged. No beat is ever dropped or repeated.
//   - in_ready = IDLE | (SHIFT & ser_last & ser_ready). This is a
//     combinational path from ser_ready. In the zero-bubble case (last beat
//     accepted and in_valid high): mux_a <= in_data, mux_s <= FIRST, stay
//     in SHIFT.
//   - in_data is sampled only on an in_valid & in_ready cycle. in_valid
//     outside that cycle is ignored.
//   - Latency: word accepted at edge N -> first beat valid in cycle N+1.
//     Throughput is WIDTH beats per word, with no bubble between words when
//     ser_ready and in_valid stay high.
//   - mux_s never leaves [0, WIDTH-1]. It does not wrap inside a word.
//   - The block does not inspect mux_y. The contract is mux_y == mux_a[mux_s].
//
// TESTING (bench instantiates mux_serializer + mux, WIDTH=8)
//   1. Assert rst_n low, then release -> in_ready=1, ser_valid=0, mux_s=0,
//      mux_a=0.
//   2. Send 8'hA5 with ser_ready=1 -> 8 beats, bits 1,0,1,0,0,1,0,1,
//      mux_s 0..7, ser_last on beat 8 only, then IDLE.
//   3. Send 8'hA5 and toggle ser_ready randomly -> same 8-bit sequence.
//      ser_bit and mux_s are stable during every stall. in_ready=0
//      until the last beat is accepted.
//   4. Send 8'hA5 then 8'h3C with in_valid held high -> 16 consecutive
//      valid beats, no idle cycle. The second word starts at mux_s=0.
//   5. Set MSB_FIRST=1 and send 8'h80 -> mux_s 7..0, bits 1,0,0,0,0,0,0,0,
//      ser_last when mux_s=0.
//   6. Drop rst_n during beat 3 of 8'hFF -> ser_valid=0 immediately,
//      without waiting for clk. After release, 8'h01 serializes from
//      mux_s=0 as 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/mux_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_serializer_if
// Brief    : Handshake and mux-side bundle between mux_serializer and its
//            upstream word source, downstream bit sink and the WIDTH:1 mux.
// Revision : 1.0  initial release
// ============================================================================
interface mux_serializer_if #(
    parameter int WIDTH = 8
) ();
    localparam int SEL_W = $clog2(WIDTH);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] mux_a;
    logic [SEL_W-1:0] mux_s;
    logic             mux_y;
    logic             ser_bit;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;

    // master: the serializer itself; slave: everything around it
    modport master (
        input  in_data, in_valid, mux_y, ser_ready,
        output in_ready, mux_a, mux_s, ser_bit, ser_valid, ser_last
    );

    modport slave (
        output in_data, in_valid, mux_y, ser_ready,
        input  in_ready, mux_a, mux_s, ser_bit, ser_valid, ser_last
    );
endinterface
`default_nettype wire

// File: rtl/mux_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mux_serializer
// Brief    : Holds one WIDTH-bit word on the mux data input and walks the mux
//            select across it, presenting mux_y as a valid/ready bit stream.
// Revision : 1.0  initial release
// ============================================================================
module mux_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_serializer_if.master     bus
);
    localparam int SEL_W = $clog2(WIDTH);

    localparam logic [SEL_W-1:0] c_ONE   = SEL_W'(1);
    localparam logic [SEL_W-1:0] c_MAXI  = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] c_FIRST = MSB_FIRST ? c_MAXI : '0;
    localparam logic [SEL_W-1:0] c_LASTI = MSB_FIRST ? '0 : c_MAXI;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] w_a_nxt;
    logic [SEL_W-1:0] r_s;
    logic [SEL_W-1:0] w_s_nxt;
    logic [SEL_W-1:0] w_s_step;
    logic             w_last;
    logic             w_in_ready;
    logic             w_accept;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_s_step = r_s - c_ONE;
        end else begin : g_lsb_first
            assign w_s_step = r_s + c_ONE;
        end
    endgenerate

    // Gated by state so ser_last stays low in IDLE even though r_s parks on LASTI.
    assign w_last     = (r_state == ST_SHIFT) && (r_s == c_LASTI);
    assign w_in_ready = (r_state == ST_IDLE) || (w_last && bus.ser_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_s_nxt     = r_s;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_a_nxt     = bus.in_data;
                    w_s_nxt     = c_FIRST;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.ser_ready) begin
                    if (!w_last) begin
                        w_s_nxt = w_s_step;
                    end else if (w_accept) begin
                        // Zero-bubble reload: next word's first beat follows directly.
                        w_a_nxt     = bus.in_data;
                        w_s_nxt     = c_FIRST;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_s     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_s     <= w_s_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mux_a     = r_a;
    assign bus.mux_s     = r_s;
    assign bus.ser_bit   = bus.mux_y;
    assign bus.ser_valid = (r_state == ST_SHIFT);
    assign bus.ser_last  = w_last;

endmodule
`default_nettype wire

// File: tb/tb_mux_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_serializer
// Brief    : Directed self-checking bench for mux_serializer (LSB- and
//            MSB-first instances, each driving a behavioural WIDTH:1 mux).
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_serializer;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mux_serializer_if #(.WIDTH(WIDTH)) if_l ();
    mux_serializer_if #(.WIDTH(WIDTH)) if_m ();

    // WIDTH:1 mux model: y = a[s]
    assign if_l.mux_y = if_l.mux_a[if_l.mux_s];
    assign if_m.mux_y = if_m.mux_a[if_m.mux_s];

    mux_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l.master)
    );

    mux_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_m.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({if_l.in_ready, if_l.ser_valid, if_l.ser_last, if_l.mux_s, if_l.mux_a} !== {1'b1, 1'b0, 1'b0, 3'd0, 8'h00}) begin
            n_err++;
            $display("FAIL reset.async: got rdy/vld/last/s/a=%b/%b/%b/%0d/%h want 1/0/0/0/00",
                     if_l.in_ready, if_l.ser_valid, if_l.ser_last, if_l.mux_s, if_l.mux_a);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({if_l.in_ready, if_l.ser_valid, if_l.ser_last, if_l.mux_s, if_l.mux_a} !== {1'b1, 1'b0, 1'b0, 3'd0, 8'h00}) begin
            n_err++;
            $display("FAIL reset.release: got rdy/vld/last/s/a=%b/%b/%b/%0d/%h want 1/0/0/0/00",
                     if_l.in_ready, if_l.ser_valid, if_l.ser_last, if_l.mux_s, if_l.mux_a);
        end
        n_cmp++;
        if ({if_m.in_ready, if_m.ser_valid, if_m.mux_s, if_m.mux_a} !== {1'b1, 1'b0, 3'd0, 8'h00}) begin
            n_err++;
            $display("FAIL reset.msb_inst: got rdy/vld/s/a=%b/%b/%0d/%h want 1/0/0/00",
                     if_m.in_ready, if_m.ser_valid, if_m.mux_s, if_m.mux_a);
        end
    endtask

    task automatic test_basic();
        logic [7:0] w;
        w = 8'hA5;
        @(posedge clk); #1;
        if_l.in_data = w; if_l.in_valid = 1'b1; if_l.ser_ready = 1'b1;
        #1;
        n_cmp++;
        if (if_l.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic.idle_ready: got %b want 1", if_l.in_ready);
        end
        @(posedge clk); #1;
        if_l.in_valid = 1'b0; if_l.in_data = 8'h00;
        #1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({if_l.ser_valid, if_l.mux_s, if_l.ser_bit, if_l.ser_last, if_l.in_ready} !==
                {1'b1, 3'(i), w[i], (i == 7), (i == 7)}) begin
                n_err++;
                $display("FAIL basic.beat%0d: got vld/s/bit/last/rdy=%b/%0d/%b/%b/%b want 1/%0d/%b/%b/%b",
                         i, if_l.ser_valid, if_l.mux_s, if_l.ser_bit, if_l.ser_last, if_l.in_ready,
                         i, w[i], (i == 7), (i == 7));
            end
            @(posedge clk); #2;
        end
        n_cmp++;
        if ({if_l.ser_valid, if_l.ser_last, if_l.in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL basic.back_to_idle: got vld/last/rdy=%b/%b/%b want 0/0/1",
                     if_l.ser_valid, if_l.ser_last, if_l.in_ready);
        end
    endtask

    task automatic test_stall();
        logic [7:0]  w;
        logic [19:0] pat;
        int          k;
        int          cyc;
        w   = 8'hA5;
        pat = 20'b1011_0010_1110_0100_1100;
        k   = 0;
        cyc = 0;
        @(posedge clk); #1;
        if_l.in_data = w; if_l.in_valid = 1'b1; if_l.ser_ready = 1'b0;
        @(posedge clk); #1;
        if_l.in_valid = 1'b0; if_l.in_data = 8'hFF;
        while (k < 8 && cyc < 100) begin
            if_l.ser_ready = pat[cyc % 20];
            #1;
            n_cmp++;
            if ({if_l.ser_valid, if_l.mux_s, if_l.ser_bit, if_l.ser_last, if_l.in_ready} !==
                {1'b1, 3'(k), w[k], (k == 7), (k == 7) && if_l.ser_ready}) begin
                n_err++;
                $display("FAIL stall.cyc%0d: got vld/s/bit/last/rdy=%b/%0d/%b/%b/%b want 1/%0d/%b/%b/%b",
                         cyc, if_l.ser_valid, if_l.mux_s, if_l.ser_bit, if_l.ser_last, if_l.in_ready,
                         k, w[k], (k == 7), (k == 7) && if_l.ser_ready);
            end
            if (if_l.ser_ready) k++;
            cyc++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (k != 8) begin
            n_err++;
            $display("FAIL stall.timeout: got %0d beats want 8", k);
        end
        if_l.ser_ready = 1'b1;
        #1;
        n_cmp++;
        if ({if_l.ser_valid, if_l.in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL stall.end_idle: got vld/rdy=%b/%b want 0/1", if_l.ser_valid, if_l.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words;
        logic [7:0]  w;
        int          idx;
        words = 16'h3CA5;
        @(posedge clk); #1;
        if_l.in_data = words[7:0]; if_l.in_valid = 1'b1; if_l.ser_ready = 1'b1;
        @(posedge clk); #1;
        if_l.in_data = words[15:8];
        #1;
        for (int j = 0; j < 16; j++) begin
            w   = (j < 8) ? words[7:0] : words[15:8];
            idx = j % 8;
            n_cmp++;
            if ({if_l.ser_valid, if_l.mux_a, if_l.mux_s, if_l.ser_bit, if_l.ser_last} !==
                {1'b1, w, 3'(idx), w[idx], (idx == 7)}) begin
                n_err++;
                $display("FAIL b2b.beat%0d: got vld/a/s/bit/last=%b/%h/%0d/%b/%b want 1/%h/%0d/%b/%b",
                         j, if_l.ser_valid, if_l.mux_a, if_l.mux_s, if_l.ser_bit, if_l.ser_last,
                         w, idx, w[idx], (idx == 7));
            end
            @(posedge clk); #1;
            if (j == 7) if_l.in_valid = 1'b0;
            #1;
        end
        n_cmp++;
        if ({if_l.ser_valid, if_l.in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b.end_idle: got vld/rdy=%b/%b want 0/1", if_l.ser_valid, if_l.in_ready);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] w;
        int         s;
        w = 8'h80;
        @(posedge clk); #1;
        if_m.in_data = w; if_m.in_valid = 1'b1; if_m.ser_ready = 1'b1;
        @(posedge clk); #1;
        if_m.in_valid = 1'b0;
        #1;
        for (int j = 0; j < 8; j++) begin
            s = 7 - j;
            n_cmp++;
            if ({if_m.ser_valid, if_m.mux_s, if_m.ser_bit, if_m.ser_last} !==
                {1'b1, 3'(s), w[s], (s == 0)}) begin
                n_err++;
                $display("FAIL msb.beat%0d: got vld/s/bit/last=%b/%0d/%b/%b want 1/%0d/%b/%b",
                         j, if_m.ser_valid, if_m.mux_s, if_m.ser_bit, if_m.ser_last, s, w[s], (s == 0));
            end
            @(posedge clk); #2;
        end
        n_cmp++;
        if ({if_m.ser_valid, if_m.in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL msb.end_idle: got vld/rdy=%b/%b want 0/1", if_m.ser_valid, if_m.in_ready);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        @(posedge clk); #1;
        if_l.in_data = 8'hFF; if_l.in_valid = 1'b1; if_l.ser_ready = 1'b1;
        @(posedge clk); #1;
        if_l.in_valid = 1'b0;
        // beats 1 and 2 go by, then reset lands mid-cycle in beat 3
        @(posedge clk); @(posedge clk); #2;
        n_cmp++;
        if ({if_l.ser_valid, if_l.mux_s} !== {1'b1, 3'd2}) begin
            n_err++;
            $display("FAIL areset.pre: got vld/s=%b/%0d want 1/2", if_l.ser_valid, if_l.mux_s);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({if_l.ser_valid, if_l.in_ready, if_l.ser_last, if_l.mux_s, if_l.mux_a} !== {1'b0, 1'b1, 1'b0, 3'd0, 8'h00}) begin
            n_err++;
            $display("FAIL areset.immediate: got vld/rdy/last/s/a=%b/%b/%b/%0d/%h want 0/1/0/0/00",
                     if_l.ser_valid, if_l.in_ready, if_l.ser_last, if_l.mux_s, if_l.mux_a);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        w = 8'h01;
        @(posedge clk); #1;
        if_l.in_data = w; if_l.in_valid = 1'b1;
        @(posedge clk); #1;
        if_l.in_valid = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({if_l.ser_valid, if_l.mux_s, if_l.ser_bit, if_l.ser_last} !==
                {1'b1, 3'(i), w[i], (i == 7)}) begin
                n_err++;
                $display("FAIL areset.beat%0d: got vld/s/bit/last=%b/%0d/%b/%b want 1/%0d/%b/%b",
                         i, if_l.ser_valid, if_l.mux_s, if_l.ser_bit, if_l.ser_last, i, w[i], (i == 7));
            end
            @(posedge clk); #2;
        end
        n_cmp++;
        if (if_l.ser_valid !== 1'b0) begin
            n_err++;
            $display("FAIL areset.end_idle: got vld=%b want 0", if_l.ser_valid);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        if_l.in_data = '0; if_l.in_valid = 1'b0; if_l.ser_ready = 1'b1;
        if_m.in_data = '0; if_m.in_valid = 1'b0; if_m.ser_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_msb_first();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
